bus_master_port: RTL and testbench

BUS_MASTER_PORT -- requirements
Module: bus_master_port

---
 rtl/bus_master_port.sv | 188 ++++++++++++++++++
 tb/tb_bus_master_port.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// Serial bus master: arbitrates for the bus, sends an address/mode/data frame MSB first,
// then waits for a write acknowledge or shifts in a read byte, with a bounded first response.
//
// state      | meaning
// S_IDLE     | waiting for an armed write/read request
// S_REQ      | bus_req high, waiting for bus_grant
// S_ADDR     | driving SLAVE_ADDR, 4 bits
// S_MODE     | driving mode bit (1 = write)
// S_WDATA    | driving write payload, 8 bits
// S_WAIT_ACK | waiting for bus_ack, bounded by ACK_TIMEOUT
// S_RDATA    | collecting 8 read bits; only the first bit is time-bounded
// S_DONE     | one-cycle tx_done, back to IDLE
module bus_master_port #(
    parameter logic [3:0] SLAVE_ADDR  = 4'd1,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] instruction,
    input  logic [7:0] data_in,
    output logic       tx_done,
    output logic       error,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       bus_req,
    input  logic       bus_grant,
    output logic       bus_valid,
    output logic       bus_sdata,
    input  logic       bus_ack,
    input  logic       bus_rvalid,
    input  logic       bus_rdata
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADDR, S_MODE, S_WDATA, S_WAIT_ACK, S_RDATA, S_DONE
    } state_t;

    state_t          state_q;
    logic            armed_q;
    logic            mode_q;
    logic [7:0]      data_q;
    logic [6:0]      rd_q;
    logic [2:0]      bit_cnt_q;
    logic [TW-1:0]   tout_q;
    logic            tx_done_q;
    logic            error_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            busy_q;
    logic            bus_req_q;
    logic            bus_valid_q;
    logic            bus_sdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b1;
            mode_q      <= 1'b0;
            data_q      <= 8'h00;
            rd_q        <= 7'h00;
            bit_cnt_q   <= 3'd0;
            tout_q      <= '0;
            tx_done_q   <= 1'b0;
            error_q     <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_sdata_q <= 1'b0;
        end else begin
            // Re-arm on any idle instruction; entering DONE below overrides this.
            if (instruction == 2'b00) armed_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (armed_q && (instruction == 2'b10 || instruction == 2'b01)) begin
                        data_q    <= data_in;
                        mode_q    <= instruction[1];
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        bus_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        bit_cnt_q   <= 3'd0;
                        bus_valid_q <= 1'b1;
                        bus_sdata_q <= SLAVE_ADDR[3];
                        state_q     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bit_cnt_q == 3'd3) begin
                        bus_sdata_q <= mode_q;
                        state_q     <= S_MODE;
                    end else begin
                        bit_cnt_q   <= bit_cnt_q + 3'd1;
                        bus_sdata_q <= SLAVE_ADDR[2'(3'd2 - bit_cnt_q)];
                    end
                end
                S_MODE: begin
                    bit_cnt_q <= 3'd0;
                    if (mode_q) begin
                        bus_sdata_q <= data_q[7];
                        data_q      <= {data_q[6:0], 1'b0};
                        state_q     <= S_WDATA;
                    end else begin
                        tout_q      <= '0;
                        bus_valid_q <= 1'b0;
                        bus_sdata_q <= 1'b0;
                        state_q     <= S_RDATA;
                    end
                end
                S_WDATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        tout_q      <= '0;
                        bus_valid_q <= 1'b0;
                        bus_sdata_q <= 1'b0;
                        state_q     <= S_WAIT_ACK;
                    end else begin
                        bit_cnt_q   <= bit_cnt_q + 3'd1;
                        bus_sdata_q <= data_q[7];
                        data_q      <= {data_q[6:0], 1'b0};
                    end
                end
                S_WAIT_ACK: begin
                    if (bus_ack || tout_q == TO_LAST) begin
                        error_q   <= ~bus_ack;
                        tx_done_q <= 1'b1;
                        bus_req_q <= 1'b0;
                        armed_q   <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        tout_q <= tout_q + 1'b1;
                    end
                end
                S_RDATA: begin
                    if (bus_rvalid) begin
                        rd_q      <= {rd_q[5:0], bus_rdata};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_q  <= {rd_q, bus_rdata};
                            rx_valid_q <= 1'b1;
                            tx_done_q  <= 1'b1;
                            bus_req_q  <= 1'b0;
                            armed_q    <= 1'b0;
                            state_q    <= S_DONE;
                        end
                    end else if (bit_cnt_q == 3'd0) begin
                        // Only the wait for the first bit is bounded.
                        if (tout_q == TO_LAST) begin
                            error_q   <= 1'b1;
                            tx_done_q <= 1'b1;
                            bus_req_q <= 1'b0;
                            armed_q   <= 1'b0;
                            state_q   <= S_DONE;
                        end else begin
                            tout_q <= tout_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    tx_done_q  <= 1'b0;
                    rx_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_done   = tx_done_q;
    assign error     = error_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign bus_req   = bus_req_q;
    assign bus_valid = bus_valid_q;
    assign bus_sdata = bus_sdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Randomized and directed transactions for bus_master_port, checked cycle by cycle against
// frame contents and latencies derived from the protocol's timing rules.
module tb_bus_master_port;

    localparam logic [3:0] SA = 4'd1;
    localparam int         TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] instruction;
    logic [7:0] data_in;
    logic       bus_grant, bus_ack, bus_rvalid, bus_rdata;
    logic       tx_done, error, rx_valid, busy, bus_req, bus_valid, bus_sdata;
    logic [7:0] rx_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_rx = 8'h00;

    bus_master_port #(.SLAVE_ADDR(SA), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .data_in(data_in),
        .tx_done(tx_done), .error(error), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .bus_req(bus_req), .bus_grant(bus_grant), .bus_valid(bus_valid),
        .bus_sdata(bus_sdata), .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_done"}, 16'(tx_done), 16'h0);
        chk({tag, "_error"}, 16'(error), 16'h0);
        chk({tag, "_rx_data"}, 16'(rx_data), 16'h0);
        chk({tag, "_rx_valid"}, 16'(rx_valid), 16'h0);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
        chk({tag, "_bus_req"}, 16'(bus_req), 16'h0);
        chk({tag, "_bus_valid"}, 16'(bus_valid), 16'h0);
        chk({tag, "_bus_sdata"}, 16'(bus_sdata), 16'h0);
    endtask

    // g: REQ cycles before grant; a: WAIT_ACK cycles before ack (>=TO never);
    // f: RDATA cycles before first bit (>=TO times out); rst_at: cycle to reset (0 = none).
    task automatic run_txn(input bit wr, input logic [7:0] d, input int g, input int a,
                           input int f, input int maxgap, input logic [7:0] rbyte,
                           input bit hold, input int rst_at);
        bit          sv[$];
        bit          sb[$];
        int          done_n, fstart, flen, idx, gap;
        bit          err, stop;
        logic [12:0] frame;
        logic [7:0]  new_rx;
        logic        exp_sd;

        frame  = {SA, wr, d};
        flen   = wr ? 13 : 5;
        fstart = 2 + g;
        if (wr) begin
            err    = (a >= TO);
            done_n = 15 + g + (err ? TO : a + 1);
        end else begin
            for (int i = 0; i < f; i++) begin sv.push_back(1'b0); sb.push_back(1'($urandom)); end
            for (int i = 0; i < 8; i++) begin
                gap = (i > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                for (int k = 0; k < gap; k++) begin sv.push_back(1'b0); sb.push_back(1'($urandom)); end
                sv.push_back(1'b1);
                sb.push_back(rbyte[7-i]);
            end
            err    = (f >= TO);
            done_n = 7 + g + (err ? TO : sv.size());
        end
        new_rx = (!wr && !err) ? rbyte : exp_rx;

        @(negedge clk);
        instruction = wr ? 2'b10 : 2'b01;
        data_in     = d;
        bus_grant   = 1'b0;
        bus_ack     = 1'b0;
        bus_rvalid  = 1'b0;
        stop        = 1'b0;

        for (int n = 1; n <= done_n + 1 && !stop; n++) begin
            @(negedge clk);
            chk("bus_req", 16'(bus_req), 16'(n < done_n));
            chk("busy", 16'(busy), 16'(n <= done_n));
            chk("bus_valid", 16'(bus_valid), 16'(n >= fstart && n < fstart + flen));
            exp_sd = (n >= fstart && n < fstart + flen) ? frame[12 - (n - fstart)] : 1'b0;
            chk("bus_sdata", 16'(bus_sdata), 16'(exp_sd));
            chk("tx_done", 16'(tx_done), 16'(n == done_n));
            chk("rx_valid", 16'(rx_valid), 16'(n == done_n && !wr && !err));
            chk("error", 16'(error), 16'(n >= done_n ? err : 1'b0));
            chk("rx_data", 16'(rx_data), 16'(n >= done_n ? new_rx : exp_rx));

            if (n >= done_n) instruction = hold ? 2'b10 : 2'b00;
            else             instruction = 2'($urandom_range(3, 1));
            data_in   = 8'($urandom);
            bus_grant = (n < 1 + g) ? 1'b0 : (n == 1 + g) ? 1'b1 : 1'($urandom);
            bus_rdata = 1'($urandom);
            if (wr) begin
                bus_ack    = (n == 15 + g + a) ? 1'b1 : (n < 15 + g) ? 1'($urandom) : 1'b0;
                bus_rvalid = 1'($urandom);
            end else begin
                bus_ack = 1'($urandom);
                idx     = n - (7 + g);
                if (idx < 0)              bus_rvalid = 1'($urandom);
                else if (idx < sv.size()) begin bus_rvalid = sv[idx]; bus_rdata = sb[idx]; end
                else                      bus_rvalid = 1'b0;
            end

            if (n == rst_at) begin
                #1 reset = 1'b1;
                #1 chk_all_zero("mid_reset");
                exp_rx = 8'h00;
                @(negedge clk);
                reset       = 1'b0;
                instruction = 2'b00;
                stop        = 1'b1;
            end
        end
        if (!stop) exp_rx = new_rx;
        bus_grant  = 1'b0;
        bus_ack    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        instruction = 2'b10;
        data_in     = 8'hFF;
        bus_grant   = 1'b1;
        bus_ack     = 1'b1;
        bus_rvalid  = 1'b1;
        bus_rdata   = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        instruction = 2'b00;
        bus_grant   = 1'b0;
        bus_ack     = 1'b0;
        bus_rvalid  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset");

        run_txn(1'b1, 8'hA5, 0, 0, 0, 0, 8'h00, 1'b0, 0);
        run_txn(1'b0, 8'h00, 0, 0, 0, 0, 8'h3C, 1'b0, 0);
        run_txn(1'b1, 8'h5A, 0, 99, 0, 0, 8'h00, 1'b0, 0);
        run_txn(1'b1, 8'hC3, 10, 2, 0, 0, 8'h00, 1'b0, 0);
        run_txn(1'b1, 8'h81, 1, 15, 0, 0, 8'h00, 1'b0, 0);
        run_txn(1'b0, 8'h00, 2, 0, 15, 3, 8'h96, 1'b0, 0);
        run_txn(1'b0, 8'h00, 0, 0, 20, 3, 8'h11, 1'b0, 0);

        run_txn(1'b1, 8'h77, 0, 1, 0, 0, 8'h00, 1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("held_tx_done", 16'(tx_done), 16'h0);
            chk("held_busy", 16'(busy), 16'h0);
        end
        @(negedge clk);
        instruction = 2'b00;
        run_txn(1'b1, 8'h3E, 0, 0, 0, 0, 8'h00, 1'b0, 0);

        run_txn(1'b0, 8'h00, 0, 0, 0, 1, 8'hE7, 1'b0, 0);
        run_txn(1'b1, 8'hA5, 0, 0, 0, 0, 8'h00, 1'b0, 9);
        @(negedge clk);
        chk("after_reset_tx_done", 16'(tx_done), 16'h0);
        chk("after_reset_rx_data", 16'(rx_data), 16'h0);
        run_txn(1'b1, 8'h42, 0, 0, 0, 0, 8'h00, 1'b0, 0);

        for (int t = 0; t < 24; t++) begin
            run_txn(1'($urandom), 8'($urandom), int'($urandom_range(3, 0)),
                    ($urandom_range(5, 0) == 0) ? 20 : int'($urandom_range(3, 0)),
                    ($urandom_range(5, 0) == 0) ? 20 : int'($urandom_range(3, 0)),
                    3, 8'($urandom), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
